vmp: RTL and testbench

Coin-evaluation block of the vending-machine datapath. It accepts a packed coin vector describing the coins a client inserted and computes the total credit. It decides whether the product is sold by comparing the credit against a fixed price, and reports the change to return. It sits between the coin-acceptor front end and the dispense/change actuators.

---
 rtl/vmp.sv | 127 ++++++++++++
 tb/tb_vmp.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vmp.sv
`default_nettype none
// ============================================================================
// Module      : vmp
// Description : Vending-machine coin evaluation. Sums a latched coin vector
//               over three cycles, compares against the price, reports
//               sale/refund and saturated change.
// Revision    : 1.0  initial release
// ============================================================================
module vmp #(
  parameter int PRICE   = 10,
  parameter int DEN_HI  = 5,
  parameter int DEN_MID = 2,
  parameter int DEN_LO  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] clientcoin,
  output logic       conclusion,
  output logic [3:0] remcach
);

  localparam logic [5:0] c_price   = 6'(PRICE);
  localparam logic [5:0] c_den_hi  = 6'(DEN_HI);
  localparam logic [5:0] c_den_mid = 6'(DEN_MID);
  localparam logic [5:0] c_den_lo  = 6'(DEN_LO);
  localparam logic [1:0] c_last_idx = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    EVAL = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [8:0] r_coin_q, w_coin_q_nxt;
  logic [5:0] r_acc, w_acc_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic       r_conclusion, w_conclusion_nxt;
  logic [3:0] r_remcach, w_remcach_nxt;

  logic [2:0] w_field;
  logic [5:0] w_den;
  logic [5:0] w_term;
  logic       w_accept;
  logic [5:0] w_credit_out;
  logic [3:0] w_credit_sat;

  // Field/denomination selected by the running index: lo, mid, hi.
  always_comb begin
    w_field = r_coin_q[2:0];
    w_den   = c_den_lo;
    case (r_idx)
      2'd0:    begin w_field = r_coin_q[2:0]; w_den = c_den_lo;  end
      2'd1:    begin w_field = r_coin_q[5:3]; w_den = c_den_mid; end
      default: begin w_field = r_coin_q[8:6]; w_den = c_den_hi;  end
    endcase
  end

  assign w_term       = {3'b000, w_field} * w_den;
  assign w_accept     = (r_acc >= c_price);
  assign w_credit_out = w_accept ? (r_acc - c_price) : r_acc;
  assign w_credit_sat = (w_credit_out > 6'd15) ? 4'hf : w_credit_out[3:0];

  always_comb begin
    w_state_nxt      = r_state;
    w_coin_q_nxt     = r_coin_q;
    w_acc_nxt        = r_acc;
    w_idx_nxt        = r_idx;
    w_conclusion_nxt = r_conclusion;
    w_remcach_nxt    = r_remcach;
    case (r_state)
      IDLE: begin
        if (clientcoin != 9'd0) begin
          w_coin_q_nxt = clientcoin;
          w_acc_nxt    = 6'd0;
          w_idx_nxt    = 2'd0;
          w_state_nxt  = SUM;
        end
      end
      SUM: begin
        w_acc_nxt = r_acc + w_term;
        if (r_idx == c_last_idx) begin
          w_state_nxt = EVAL;
        end else begin
          w_idx_nxt = r_idx + 2'd1;
        end
      end
      EVAL: begin
        w_conclusion_nxt = w_accept;
        w_remcach_nxt    = w_credit_sat;
        w_state_nxt      = HOLD;
      end
      default: begin
        // Any nonzero input is ignored until the client withdraws to zero.
        if (clientcoin == 9'd0) begin
          w_conclusion_nxt = 1'b0;
          w_remcach_nxt    = 4'd0;
          w_state_nxt      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_coin_q     <= 9'd0;
      r_acc        <= 6'd0;
      r_idx        <= 2'd0;
      r_conclusion <= 1'b0;
      r_remcach    <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_coin_q     <= w_coin_q_nxt;
      r_acc        <= w_acc_nxt;
      r_idx        <= w_idx_nxt;
      r_conclusion <= w_conclusion_nxt;
      r_remcach    <= w_remcach_nxt;
    end
  end

  assign conclusion = r_conclusion;
  assign remcach    = r_remcach;

endmodule
`default_nettype wire

// File: tb/tb_vmp.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmp
// Description : Table-driven, scoreboard-checked bench for vmp (PRICE = 10).
// Revision    : 1.0  initial release
// ============================================================================
module tb_vmp;

  logic       clk;
  logic       rst_n;
  logic [8:0] clientcoin;
  logic       conclusion;
  logic [3:0] remcach;

  vmp #(.PRICE(10), .DEN_HI(5), .DEN_MID(2), .DEN_LO(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clientcoin (clientcoin),
    .conclusion (conclusion),
    .remcach    (remcach)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] coin;
    logic       conc;
    logic [3:0] rem;
  } vec_t;

  typedef struct packed {
    logic       conc;
    logic [3:0] rem;
  } exp_t;

  localparam int c_nvec = 14;
  vec_t tbl [c_nvec];
  exp_t sb [$];
  int   n_checks;
  int   n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Waits (bounded) for a result after the sampling edge, then checks
  // latency and pops the scoreboard entry.
  task automatic collect(input string tag);
    int   cyc;
    exp_t e;
    cyc = 0;
    #1;
    while (conclusion == 1'b0 && remcach == 4'd0 && cyc < 10) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    chk({tag, "_latency"}, cyc, 4);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_conclusion"}, {31'd0, conclusion}, {31'd0, e.conc});
      chk({tag, "_remcach"}, {28'd0, remcach}, {28'd0, e.rem});
    end
  endtask

  task automatic hold_check(input string tag, input logic c, input logic [3:0] r, input int n);
    repeat (n) @(posedge clk);
    #1;
    chk({tag, "_hold_conc"}, {31'd0, conclusion}, {31'd0, c});
    chk({tag, "_hold_rem"}, {28'd0, remcach}, {28'd0, r});
  endtask

  task automatic release_check(input string tag);
    @(negedge clk);
    clientcoin = 9'd0;
    @(posedge clk);
    #1;
    chk({tag, "_clr_conc"}, {31'd0, conclusion}, 0);
    chk({tag, "_clr_rem"}, {28'd0, remcach}, 0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    clientcoin = 9'd0;
    rst_n      = 1'b0;

    // Expected values derived by hand: credit = 5*hi + 2*mid + lo, price 10.
    tbl[0]  = '{9'b010_010_001, 1'b1, 4'd5};   // 15
    tbl[1]  = '{9'b001_000_000, 1'b0, 4'd5};   // 5, refund
    tbl[2]  = '{9'b000_101_000, 1'b1, 4'd0};   // exactly 10
    tbl[3]  = '{9'b111_111_111, 1'b1, 4'd15};  // 56, change 46 saturated
    tbl[4]  = '{9'b000_000_111, 1'b0, 4'd7};   // 7
    tbl[5]  = '{9'b000_111_111, 1'b1, 4'd11};  // 21
    tbl[6]  = '{9'b011_000_001, 1'b1, 4'd6};   // 16
    tbl[7]  = '{9'b010_000_000, 1'b1, 4'd0};   // 10
    tbl[8]  = '{9'b000_100_001, 1'b0, 4'd9};   // 9, one below price
    tbl[9]  = '{9'b111_000_000, 1'b1, 4'd15};  // 35, change 25 saturated
    tbl[10] = '{9'b000_000_001, 1'b0, 4'd1};   // 1
    tbl[11] = '{9'b101_000_000, 1'b1, 4'd15};  // 25, change exactly 15
    tbl[12] = '{9'b100_000_110, 1'b1, 4'd15};  // 26, change 16 saturated
    tbl[13] = '{9'b000_011_011, 1'b0, 4'd9};   // 9

    #12;
    chk("reset_conc", {31'd0, conclusion}, 0);
    chk("reset_rem", {28'd0, remcach}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < c_nvec; i++) begin
      @(negedge clk);
      clientcoin = tbl[i].coin;
      sb.push_back('{conc: tbl[i].conc, rem: tbl[i].rem});
      @(posedge clk);
      collect($sformatf("vec%0d", i));
      hold_check($sformatf("vec%0d", i), tbl[i].conc, tbl[i].rem, 2);
      release_check($sformatf("vec%0d", i));
    end

    // Input glitch during SUM must not alter the latched vector; a new
    // nonzero value in HOLD is ignored until the input returns to zero.
    @(negedge clk);
    clientcoin = 9'b010_010_001;
    sb.push_back('{conc: 1'b1, rem: 4'd5});
    @(posedge clk);
    @(negedge clk);
    clientcoin = 9'b000_000_001;
    collect("glitch");
    hold_check("glitch", 1'b1, 4'd5, 3);
    release_check("glitch");

    // Asynchronous reset while in HOLD clears outputs without a clock edge.
    @(negedge clk);
    clientcoin = 9'b001_000_000;
    sb.push_back('{conc: 1'b0, rem: 4'd5});
    @(posedge clk);
    collect("rst_hold");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_hold_conc", {31'd0, conclusion}, 0);
    chk("rst_hold_rem", {28'd0, remcach}, 0);
    @(negedge clk);
    clientcoin = 9'd0;
    rst_n = 1'b1;
    @(negedge clk);

    // Reset between E2 and E3; held input is resampled after release.
    clientcoin = 9'b010_010_001;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sum_conc", {31'd0, conclusion}, 0);
    chk("rst_sum_rem", {28'd0, remcach}, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_sum_quiet", {27'd0, conclusion, remcach}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{conc: 1'b1, rem: 4'd5});
    @(posedge clk);
    collect("rst_resample");
    release_check("rst_resample");

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
